// File: rtl/quad_decode.sv
// Quadrature A/B decoder: synchronise, glitch-filter, Gray-decode into up/down
// steps, and keep a wrapping position count with clear/load and status pulses.
module quad_decode #(
    parameter int WIDTH = 4,
    parameter int FILT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] no,
    output logic             dir,
    output logic             step,
    output logic             err,
    output logic             ovf,
    output logic             unf
);
    localparam logic [3:0] STAB_MAX = 4'(FILT - 1);

    logic [1:0] s1, s2, ab_q;
    logic [3:0] stab;
    logic       armed;
    logic       accept, up, dn, bad;
    logic       up_ev, dn_ev, bad_ev, hold;

    always_comb begin
        accept = (s2 != ab_q) && (stab == STAB_MAX);
        up     = 1'b0;
        dn     = 1'b0;
        bad    = 1'b0;
        // {old, new}: forward Gray order is 00 -> 01 -> 11 -> 10 -> 00
        case ({ab_q, s2})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: up  = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: dn  = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: bad = 1'b1;
            default: ;
        endcase
        up_ev  = accept && armed && up;
        dn_ev  = accept && armed && dn;
        bad_ev = accept && armed && bad;
        hold   = clr || load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 2'b00;
            s2    <= 2'b00;
            ab_q  <= 2'b00;
            stab  <= 4'd0;
            armed <= 1'b0;
            no    <= '0;
            dir   <= 1'b1;
            step  <= 1'b0;
            err   <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            s1   <= {a, b};
            s2   <= s1;
            step <= 1'b0;
            err  <= 1'b0;
            ovf  <= 1'b0;
            unf  <= 1'b0;

            if (s2 == ab_q) begin
                stab <= 4'd0;
            end else if (stab == STAB_MAX) begin
                ab_q  <= s2;
                stab  <= 4'd0;
                armed <= 1'b1;
            end else begin
                stab <= stab + 4'd1;
            end

            // Direction tracks the encoder even while clr/load own the count
            if (up_ev || dn_ev)
                dir <= up_ev;

            if (clr)
                no <= '0;
            else if (load)
                no <= load_val;
            else if (up_ev)
                no <= no + WIDTH'(1);
            else if (dn_ev)
                no <= no - WIDTH'(1);

            if (!hold) begin
                step <= up_ev || dn_ev;
                err  <= bad_ev;
                ovf  <= up_ev && (&no);
                unf  <= dn_ev && (no == '0);
            end
        end
    end
endmodule

// File: tb/tb_quad_decode.sv
// Randomised and directed bench for quad_decode against a behavioural model
// that tracks encoder position as an integer 0..3 and compares per cycle.
module tb_quad_decode;
    localparam int WIDTH = 4;
    localparam int FILT  = 3;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst, a, b, clr, load;
    logic [WIDTH-1:0] load_val, no;
    logic             dir, step, err, ovf, unf;

    always #5 clk = ~clk;

    quad_decode #(.WIDTH(WIDTH), .FILT(FILT)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr), .load(load),
        .load_val(load_val), .no(no), .dir(dir), .step(step), .err(err),
        .ovf(ovf), .unf(unf)
    );

    int n_chk = 0, n_err = 0;
    int m_no, m_dir, m_step, m_err, m_ovf, m_unf, m_acc, m_run, m_armed;
    int dq[$];
    int tcnt = 0, sum_step = 0, sum_ovf = 0, first_t = -1;
    int cur, t0, save;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, tcnt);
        end
    endtask

    // Encoder phase index: 00=0, 01=1, 11=2, 10=3
    function automatic int pos(input int ab);
        return ((ab >> 1) & 1) * 2 + (((ab >> 1) ^ ab) & 1);
    endfunction

    function automatic logic [1:0] gray(input int p);
        logic [1:0] t [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        return t[((p % 4) + 4) % 4];
    endfunction

    task automatic model_edge();
        int v, d;
        bit upv, dnv, badv;
        upv = 0; dnv = 0; badv = 0;
        if (rst) begin
            m_no = 0; m_dir = 1; m_step = 0; m_err = 0; m_ovf = 0; m_unf = 0;
            m_acc = 0; m_run = 0; m_armed = 0;
            dq = '{0, 0};
        end else begin
            v = dq[0];
            m_step = 0; m_err = 0; m_ovf = 0; m_unf = 0;
            if (v == m_acc) m_run = 0;
            else if (m_run + 1 == FILT) begin
                m_run = 0;
                d = (pos(v) - pos(m_acc) + 4) % 4;
                if (m_armed != 0) begin
                    upv = (d == 1); dnv = (d == 3); badv = (d == 2);
                end
                m_acc = v;
                m_armed = 1;
            end else m_run++;
            if (upv || dnv) m_dir = upv ? 1 : 0;
            if (!(clr || load)) begin
                m_step = (upv || dnv) ? 1 : 0;
                m_err  = badv ? 1 : 0;
                m_ovf  = (upv && m_no == MOD - 1) ? 1 : 0;
                m_unf  = (dnv && m_no == 0) ? 1 : 0;
            end
            if (clr) m_no = 0;
            else if (load) m_no = int'(load_val);
            else if (upv) m_no = (m_no + 1) % MOD;
            else if (dnv) m_no = (m_no + MOD - 1) % MOD;
            void'(dq.pop_front());
            dq.push_back(int'({a, b}));
        end
    endtask

    task automatic tick(input logic [1:0] ab, input logic r, input logic c,
                        input logic l, input logic [WIDTH-1:0] lv);
        a = ab[1]; b = ab[0]; rst = r; clr = c; load = l; load_val = lv;
        @(posedge clk);
        model_edge();
        tcnt++;
        #1;
        chk("no", no, m_no);
        chk("dir", dir, m_dir);
        chk("step", step, m_step);
        chk("err", err, m_err);
        chk("ovf", ovf, m_ovf);
        chk("unf", unf, m_unf);
        if (step === 1'b1) sum_step++;
        if (ovf === 1'b1) sum_ovf++;
        if (step === 1'b1 && first_t < 0) first_t = tcnt;
    endtask

    initial begin
        dq = '{0, 0};
        // Arming: 11 held through reset, first acceptance must be silent
        repeat (3) tick(2'b11, 1, 0, 0, 0);
        repeat (8) tick(2'b11, 0, 0, 0, 0);
        chk("arm_no", no, 0);
        cur = 2;
        tick(gray(cur), 0, 1, 0, 0);

        // Forward wrap: 16 up steps from 0
        sum_step = 0; sum_ovf = 0; first_t = -1; t0 = tcnt;
        for (int i = 0; i < 16; i++) begin
            cur++;
            repeat (FILT + 1) tick(gray(cur), 0, 0, 0, 0);
        end
        repeat (FILT + 1) tick(gray(cur), 0, 0, 0, 0);
        chk("fwd_steps", sum_step, 16);
        chk("fwd_ovf", sum_ovf, 1);
        chk("fwd_lat", first_t - (t0 + 1), FILT + 1);
        chk("fwd_no", no, 0);
        chk("fwd_dir", dir, 1);

        // One down step from 0 underflows
        cur--;
        repeat (FILT + 3) tick(gray(cur), 0, 0, 0, 0);
        chk("rev_no", no, MOD - 1);
        chk("rev_dir", dir, 0);

        // Glitch shorter than FILT is ignored
        save = int'(no);
        repeat (FILT - 1) tick(gray(cur + 1), 0, 0, 0, 0);
        repeat (FILT + 3) tick(gray(cur), 0, 0, 0, 0);
        chk("glitch_no", no, save);

        // Illegal double-phase jump, then a legal up step
        cur += 2;
        repeat (FILT + 2) tick(gray(cur), 0, 0, 0, 0);
        chk("ill_no", no, save);
        cur++;
        repeat (FILT + 2) tick(gray(cur), 0, 0, 0, 0);
        chk("ill_up_no", no, (save + 1) % MOD);

        // Load on the very edge that decodes an up step
        cur++;
        for (int i = 0; i < FILT + 3; i++)
            tick(gray(cur), 0, 0, (i == FILT + 1), 4'd9);
        chk("ld_no", no, 9);
        chk("ld_dir", dir, 1);
        tick(gray(cur), 0, 1, 1, 4'd5);
        chk("cl_no", no, 0);

        // Reset while the filter is mid-count
        cur++;
        repeat (3) tick(gray(cur), 0, 0, 0, 0);
        tick(gray(cur), 1, 0, 0, 0);
        chk("rmid_no", no, 0);
        chk("rmid_dir", dir, 1);
        repeat (FILT + 5) tick(gray(cur), 0, 0, 0, 0);

        // Random walk with occasional jumps, glitches, clr/load and reset
        repeat (300) begin
            int r, hold;
            r = $urandom_range(0, 99);
            if (r < 45) cur++;
            else if (r < 85) cur--;
            else cur = $urandom_range(0, 3);
            hold = $urandom_range(1, 6);
            repeat (hold)
                tick(gray(cur), ($urandom_range(0, 199) == 0),
                     ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0),
                     WIDTH'($urandom_range(0, MOD - 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
